// File: rtl/i2s_transmitter_pkg.sv
// Shared configuration for the synth audio datapath and its I2S output stage.
// Board tops override the I2S defaults through the transmitter parameters.
package i2s_transmitter_pkg;

  localparam int AUDIO_BIT_WIDTH = 16;
  localparam int I2S_SLOT_WIDTH  = 32;
  localparam int I2S_BCLK_DIV    = 8;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // The datapath carries offset-binary samples; the DAC expects two's complement.
  function automatic logic [AUDIO_BIT_WIDTH-1:0] offset_to_twos(
    input logic [AUDIO_BIT_WIDTH-1:0] sample
  );
    return {~sample[AUDIO_BIT_WIDTH-1], sample[AUDIO_BIT_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/i2s_transmitter_bclk_generator.sv
// Divides the system clock down to the I2S bit clock and flags each falling
// bclk edge one cycle ahead so the parent can update on the same edge.
module bclk_generator
  import i2s_transmitter_pkg::*;
#(
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = (div_cnt == DIV_LAST);
  // High during the cycle whose closing edge drives bclk from 1 to 0.
  assign fall = wrap && bclk;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Serializes the mono mixer sample onto both I2S slots, latching one sample
// per frame and converting it from offset binary to two's complement.
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int BCLK_DIV   = I2S_BCLK_DIV,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [AUDIO_BIT_WIDTH-1:0] audio_in,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata,
  output logic                       sample_taken
);

  localparam int W     = AUDIO_BIT_WIDTH;
  localparam int S     = SLOT_WIDTH;
  localparam int CNT_W = $clog2(2 * S);

  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(2 * S - 1);
  localparam logic [CNT_W-1:0] RIGHT_FIRST = CNT_W'(S - 1);
  localparam logic [CNT_W-1:0] RIGHT_LAST  = CNT_W'(2 * S - 2);
  localparam logic [CNT_W-1:0] RELOAD_BIT  = CNT_W'(S);

  if (SLOT_WIDTH < AUDIO_BIT_WIDTH || BCLK_DIV < 1) begin : g_param_check
    $error("i2s_transmitter: need SLOT_WIDTH >= AUDIO_BIT_WIDTH and BCLK_DIV >= 1");
  end

  logic             fall;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] next_bit;
  logic [W-1:0]     converted;
  logic [W-1:0]     sample_reg;
  logic [S-1:0]     shift_reg;
  slot_e            next_slot;

  function automatic logic [S-1:0] align_msb(input logic [W-1:0] value);
    return S'(value) << (S - W);
  endfunction

  bclk_generator #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_generator (
    .clock(clock),
    .reset(reset),
    .bclk (bclk),
    .fall (fall)
  );

  assign next_bit  = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
  assign converted = offset_to_twos(audio_in);
  // Word select leads each slot's MSB by one bclk.
  assign next_slot = (next_bit >= RIGHT_FIRST && next_bit <= RIGHT_LAST) ? SLOT_RIGHT : SLOT_LEFT;
  assign sdata     = shift_reg[S-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt      <= LAST_BIT;
      lrclk        <= 1'b0;
      sample_reg   <= '0;
      shift_reg    <= '0;
      sample_taken <= 1'b0;
    end else begin
      sample_taken <= 1'b0;
      if (fall) begin
        bit_cnt <= next_bit;
        lrclk   <= (next_slot == SLOT_RIGHT);
        if (next_bit == '0) begin
          sample_reg   <= converted;
          shift_reg    <= align_msb(converted);
          sample_taken <= 1'b1;
        end else if (next_bit == RELOAD_BIT) begin
          // Right slot repeats the sample latched for the left slot.
          shift_reg <= align_msb(sample_reg);
        end else begin
          shift_reg <= {shift_reg[S-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomized scoreboard bench for the I2S transmitter: stimulus queues the
// expected bit stream per frame, monitors compare at every rising bclk.
module tb_i2s_transmitter;

  localparam int FRAME = 1024;
  localparam int FIRST_LATCH = 16;

  typedef struct packed {
    logic lr;
    logic sd;
  } bit_t;

  logic        clock;
  logic        reset;
  logic [15:0] audio_in;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        sample_taken;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   rel_stamp = 0;
  int   frame_idx = 0;
  bit   monitor_on = 1'b0;
  bit_t exp_bits[$];
  int   exp_taken[$];

  i2s_transmitter dut (
    .clock       (clock),
    .reset       (reset),
    .audio_in    (audio_in),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .sample_taken(sample_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic int relCycle();
    return cycle - rel_stamp;
  endfunction

  function automatic int latchRel(input int f);
    return FIRST_LATCH + FRAME * f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at rel cycle %0d: got %0h, expected %0h", name, relCycle(), actual, expected);
    end
  endtask

  // Reference: each frame is the two's-complement sample MSB-first, zero padded, sent twice.
  task automatic pushFrame(input logic [15:0] v, input int latch_at);
    logic [15:0] tc;
    bit_t        item;
    tc = 16'(int'(v) - 32768);
    for (int k = 0; k < 64; k++) begin
      int p;
      p = k % 32;
      item.sd = (p < 16) ? tc[15 - p] : 1'b0;
      item.lr = (((k + 1) % 64) >= 32);
      exp_bits.push_back(item);
    end
    exp_taken.push_back(latch_at);
  endtask

  task automatic waitRel(input int t);
    while (relCycle() < t) @(negedge clock);
  endtask

  task automatic startAfterReset(input logic [15:0] v);
    bit_t idle;
    audio_in  = v;
    reset     = 1'b0;
    rel_stamp = cycle;
    frame_idx = 0;
    monitor_on = 1'b1;
    idle = '0;
    exp_bits.push_back(idle);
    pushFrame(v, FIRST_LATCH);
    waitRel(7);  checkOutput("bclk_rel7", bclk, 1'b0);
    waitRel(8);  checkOutput("bclk_rel8", bclk, 1'b1);
    waitRel(15); checkOutput("bclk_rel15", bclk, 1'b1);
                 checkOutput("taken_rel15", sample_taken, 1'b0);
    waitRel(16); checkOutput("bclk_rel16", bclk, 1'b0);
                 checkOutput("taken_rel16", sample_taken, 1'b1);
                 checkOutput("lrclk_rel16", lrclk, 1'b0);
    waitRel(17); checkOutput("taken_rel17", sample_taken, 1'b0);
    waitRel(24); checkOutput("bclk_rel24", bclk, 1'b1);
  endtask

  // Changes audio_in partway through the current frame; it takes effect at the next latch.
  task automatic applyStimulus(input logic [15:0] next_val, input int offset);
    waitRel(latchRel(frame_idx) + offset);
    audio_in = next_val;
    pushFrame(next_val, latchRel(frame_idx + 1));
    frame_idx++;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_bclk"}, bclk, 1'b0);
    checkOutput({tag, "_lrclk"}, lrclk, 1'b0);
    checkOutput({tag, "_sdata"}, sdata, 1'b0);
    checkOutput({tag, "_taken"}, sample_taken, 1'b0);
  endtask

  always begin
    @(posedge bclk);
    @(negedge clock);
    if (monitor_on) begin
      if (exp_bits.size() == 0) begin
        checkOutput("bits_underflow", 32'd1, 32'd0);
      end else begin
        bit_t item;
        item = exp_bits.pop_front();
        checkOutput("sdata", sdata, item.sd);
        checkOutput("lrclk", lrclk, item.lr);
      end
    end
  end

  always @(negedge clock) begin
    if (monitor_on && !reset && sample_taken === 1'b1) begin
      if (exp_taken.size() == 0) checkOutput("taken_unexpected", 32'd1, 32'd0);
      else checkOutput("taken_cycle", relCycle(), exp_taken.pop_front());
    end
  end

  always @(lrclk) begin
    if (monitor_on) begin
      #1;
      checkOutput("lrclk_at_fall", bclk, 1'b0);
    end
  end

  initial begin
    $display("[TB] starting i2s_transmitter bench");
    reset    = 1'b1;
    audio_in = 16'h1234;
    repeat (5) @(negedge clock);
    checkResetOutputs("reset");
    startAfterReset(16'h1234);

    applyStimulus(16'h8000, 300);
    applyStimulus(16'h8000, 700);
    applyStimulus(16'hFFFF, 500);
    applyStimulus(16'h0000, 900);
    applyStimulus(16'hC000, 200);
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), $urandom_range(20, 1000));

    waitRel(latchRel(frame_idx) + 16 * 40 + 12);
    reset = 1'b1;
    @(negedge clock);
    checkResetOutputs("midreset");
    checkOutput("taken_pending", exp_taken.size(), 32'd0);
    exp_bits.delete();
    repeat (4) @(negedge clock);
    checkOutput("midreset_taken_hold", sample_taken, 1'b0);
    startAfterReset(16'($urandom));

    for (int i = 0; i < 2; i++) applyStimulus(16'($urandom), $urandom_range(20, 1000));
    waitRel(latchRel(frame_idx) + 1020);
    monitor_on = 1'b0;
    checkOutput("bits_pending", exp_bits.size(), 32'd0);
    checkOutput("taken_left", exp_taken.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
